// File: rtl/fmap_pkg.sv
// fmap_pkg: shared state type, pipeline depth and sizing helpers for the
// feature-map streamer and its companion collector.
package fmap_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    STREAM = 2'd1,
    DRAIN  = 2'd2
  } fmap_state_e;

  // Issue -> RAM data -> registered output.
  localparam int PIPE_LAT = 2;

  // Never returns less than one bit, so single-value counters still exist.
  function automatic int fmap_clog2(input int n);
    int w;
    w = 1;
    while ((1 << w) < n) w++;
    return w;
  endfunction

  function automatic int fmap_padded_side(input int d);
    return d + 2;
  endfunction

endpackage

// File: rtl/fmap_raster_cnt.sv
// fmap_raster_cnt: raster row/col counter over a SIDE x SIDE map repeated
// FRAMES times, with position flags for the first and last pixels.
module fmap_raster_cnt
  import fmap_pkg::*;
#(
  parameter int SIDE   = 9,
  parameter int FRAMES = 10,
  parameter int CW     = fmap_clog2(SIDE),
  parameter int FW     = fmap_clog2(FRAMES)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clr,
  input  logic          en,
  output logic [CW-1:0] row,
  output logic [CW-1:0] col,
  output logic          first_pix,
  output logic          last_pix,
  output logic          last_all
);

  logic [FW-1:0] frame;
  logic          col_end;
  logic          row_end;
  logic          frame_end;

  assign col_end   = (col == CW'(SIDE - 1));
  assign row_end   = (row == CW'(SIDE - 1));
  assign frame_end = (frame == FW'(FRAMES - 1));

  assign first_pix = (row == '0) && (col == '0);
  assign last_pix  = col_end && row_end;
  assign last_all  = last_pix && frame_end;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      row   <= '0;
      col   <= '0;
      frame <= '0;
    end else if (clr) begin
      row   <= '0;
      col   <= '0;
      frame <= '0;
    end else if (en) begin
      if (col_end) begin
        col <= '0;
        if (row_end) begin
          row   <= '0;
          frame <= frame_end ? '0 : frame + 1'b1;
        end else begin
          row <= row + 1'b1;
        end
      end else begin
        col <= col + 1'b1;
      end
    end
  end

endmodule

// File: rtl/fmap_stream_tx.sv
// fmap_stream_tx: streams a D x D feature map from a sync-read RAM to the conv
// engine, FRAMES times per start. Define FMAP_ZERO_PAD_EN for a zero border.
module fmap_stream_tx
  import fmap_pkg::*;
#(
  parameter int D          = 9,
  parameter int data_width = 32,
  parameter int ADDR_W     = 7,
  parameter int FRAMES     = 10
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  stall,
  output logic                  mem_rd_en,
  output logic [ADDR_W-1:0]     mem_addr,
  input  logic [data_width-1:0] mem_rdata,
  output logic [data_width-1:0] pxl_out,
  output logic                  valid_out,
  output logic                  sof_out,
  output logic                  eof_out,
  output logic                  busy,
  output logic                  done
);

`ifdef FMAP_ZERO_PAD_EN
  localparam int SIDE = fmap_padded_side(D);
`else
  localparam int SIDE = D;
`endif
  localparam int CW  = fmap_clog2(SIDE);
  localparam int DCW = fmap_clog2(PIPE_LAT);

  fmap_state_e         state;
  logic [DCW-1:0]      drain_cnt;
  logic [CW-1:0]       row;
  logic [CW-1:0]       col;
  logic                first_pix;
  logic                last_pix;
  logic                last_all;
  logic                issue;
  logic                pad;
  logic                pad_d;
  logic [PIPE_LAT-1:0] v_sh;
  logic [PIPE_LAT-1:0] sof_sh;
  logic [PIPE_LAT-1:0] eof_sh;

  assign issue = (state == STREAM) && !stall;

  fmap_raster_cnt #(
    .SIDE   (SIDE),
    .FRAMES (FRAMES)
  ) u_cnt (
    .clk       (clk),
    .rst_n     (reset),
    .clr       (state == IDLE),
    .en        (issue),
    .row       (row),
    .col       (col),
    .first_pix (first_pix),
    .last_pix  (last_pix),
    .last_all  (last_all)
  );

  always_comb begin
    pad      = 1'b0;
    mem_addr = '0;
`ifdef FMAP_ZERO_PAD_EN
    pad = (row == '0) || (col == '0) ||
          (row == CW'(SIDE - 1)) || (col == CW'(SIDE - 1));
    if (!pad)
      mem_addr = ADDR_W'((32'(row) - 32'd1) * 32'(D) + (32'(col) - 32'd1));
`else
    mem_addr = ADDR_W'(32'(row) * 32'(D) + 32'(col));
`endif
  end

  // Border pixels still occupy an issue slot but never touch the RAM.
  assign mem_rd_en = issue && !pad;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      drain_cnt <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      done <= 1'b0;
      unique case (state)
        IDLE: begin
          // The done cycle is still IDLE; a start there is deliberately dropped.
          if (done) begin
            busy <= 1'b0;
          end else if (start) begin
            state <= STREAM;
            busy  <= 1'b1;
          end
        end
        STREAM: begin
          if (issue && last_all) begin
            state     <= DRAIN;
            drain_cnt <= DCW'(PIPE_LAT - 1);
          end
        end
        DRAIN: begin
          if (drain_cnt == '0) begin
            state <= IDLE;
            done  <= 1'b1;
          end else begin
            drain_cnt <= drain_cnt - 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      v_sh    <= '0;
      sof_sh  <= '0;
      eof_sh  <= '0;
      pad_d   <= 1'b0;
      pxl_out <= '0;
    end else begin
      v_sh   <= {v_sh[PIPE_LAT-2:0], issue};
      sof_sh <= {sof_sh[PIPE_LAT-2:0], issue && first_pix};
      eof_sh <= {eof_sh[PIPE_LAT-2:0], issue && last_pix};
      pad_d  <= pad;
      if (v_sh[PIPE_LAT-2])
        pxl_out <= pad_d ? '0 : mem_rdata;
    end
  end

  assign valid_out = v_sh[PIPE_LAT-1];
  assign sof_out   = sof_sh[PIPE_LAT-1];
  assign eof_out   = eof_sh[PIPE_LAT-1];

endmodule

// File: tb/tb_fmap_stream_tx.sv
// tb_fmap_stream_tx: cycle tables for the single-frame instance plus a
// frame-sequence reference model for randomized stall/start traffic.
module tb_fmap_stream_tx;

  localparam int DW = 32;
  localparam int AW = 4;
  localparam int D  = 3;
  localparam int FA = 1;
  localparam int FB = 2;
`ifdef FMAP_ZERO_PAD_EN
  localparam bit PAD = 1'b1;
`else
  localparam bit PAD = 1'b0;
`endif
  localparam int SIDE = PAD ? D + 2 : D;
  localparam int SS   = SIDE * SIDE;

  logic clk;
  logic rst_n;

  logic          start_a, stall_a, rd_a, v_a, sof_a, eof_a, busy_a, done_a;
  logic [AW-1:0] addr_a;
  logic [DW-1:0] rdata_a, pxl_a;
  logic [DW-1:0] ram_a [2**AW];

  logic          start_b, stall_b, rd_b, v_b, sof_b, eof_b, busy_b, done_b;
  logic [AW-1:0] addr_b;
  logic [DW-1:0] rdata_b, pxl_b;
  logic [DW-1:0] ram_b [2**AW];

  int n_run, n_fail;

  fmap_stream_tx #(.D(D), .data_width(DW), .ADDR_W(AW), .FRAMES(FA)) dut_a (
    .clk(clk), .reset(rst_n), .start(start_a), .stall(stall_a),
    .mem_rd_en(rd_a), .mem_addr(addr_a), .mem_rdata(rdata_a),
    .pxl_out(pxl_a), .valid_out(v_a), .sof_out(sof_a), .eof_out(eof_a),
    .busy(busy_a), .done(done_a)
  );

  fmap_stream_tx #(.D(D), .data_width(DW), .ADDR_W(AW), .FRAMES(FB)) dut_b (
    .clk(clk), .reset(rst_n), .start(start_b), .stall(stall_b),
    .mem_rd_en(rd_b), .mem_addr(addr_b), .mem_rdata(rdata_b),
    .pxl_out(pxl_b), .valid_out(v_b), .sof_out(sof_b), .eof_out(eof_b),
    .busy(busy_b), .done(done_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) if (rd_a) rdata_a <= ram_a[addr_a];
  always @(posedge clk) if (rd_b) rdata_b <= ram_b[addr_b];

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got running expected finished");
    $fatal(1);
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_run++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Expected k-th emitted pixel of a run, straight from the raster/pad rules.
  function automatic logic [31:0] ref_pix(input int k, input bit use_b);
    int p, r, c, o, a;
    p = k % SS;
    r = p / SIDE;
    c = p % SIDE;
    o = PAD ? 1 : 0;
    if (PAD && (r == 0 || c == 0 || r == SIDE - 1 || c == SIDE - 1)) return '0;
    a = (r - o) * D + (c - o);
    return use_b ? ram_b[a] : ram_a[a];
  endfunction

  typedef struct {
    int tst;
    bit st, sl, rd;
    int ad;
    bit v;
    int p;
    bit so, eo, b, d;
  } vec_t;
  vec_t tbl[$];

  task automatic add(input int tst, input bit st, input bit sl, input bit rd, input int ad,
                     input bit v, input int p, input bit so, input bit eo, input bit b, input bit d);
    vec_t r;
    r.tst = tst; r.st = st; r.sl = sl; r.rd = rd; r.ad = ad; r.v = v; r.p = p;
    r.so = so; r.eo = eo; r.b = b; r.d = d;
    tbl.push_back(r);
  endtask

  logic [DW-1:0] got_a[$];
  int ra_nval, ra_ndone, ra_nrd, ra_first, ra_last, ra_done;

  task automatic run_a(input int max_cyc);
    ra_nval = 0; ra_ndone = 0; ra_nrd = 0; ra_first = -1; ra_last = -1; ra_done = -1;
    got_a.delete();
    start_a = 1'b1;
    for (int c = 0; c < max_cyc; c++) begin
      @(negedge clk);
      if (v_a) begin
        if (ra_first < 0) ra_first = c;
        ra_last = c;
        got_a.push_back(pxl_a);
        ra_nval++;
      end
      if (done_a) begin ra_ndone++; ra_done = c; end
      if (rd_a) ra_nrd++;
      @(posedge clk); #1;
      start_a = 1'b0;
    end
  endtask

  task automatic check_run_a(input string tag);
    int errs;
    errs = 0;
    chk({tag, " first_valid_cycle"}, ra_first, 3);
    chk({tag, " valid_count"}, ra_nval, FA * SS);
    chk({tag, " done_count"}, ra_ndone, 1);
    chk({tag, " done_after_last_valid"}, ra_done, ra_last + 1);
    chk({tag, " rd_en_count"}, ra_nrd, FA * D * D);
    foreach (got_a[k]) if (got_a[k] !== ref_pix(k, 1'b0)) errs++;
    chk({tag, " pixel_sequence_errors"}, errs, 0);
  endtask

  task automatic check_all_zero_a(input string tag);
    chk({tag, " pxl_out"}, pxl_a, 0);
    chk({tag, " valid_out"}, v_a, 0);
    chk({tag, " sof_out"}, sof_a, 0);
    chk({tag, " eof_out"}, eof_a, 0);
    chk({tag, " busy"}, busy_a, 0);
    chk({tag, " done"}, done_a, 0);
    chk({tag, " mem_rd_en"}, rd_a, 0);
    chk({tag, " mem_addr"}, addr_a, 0);
  endtask

  logic [DW-1:0] exp_q[$];
  int idx, nd, last_v, done_c;

  initial begin
    n_run = 0; n_fail = 0;
    rst_n = 1'b0;
    start_a = 1'b0; stall_a = 1'b0; start_b = 1'b0; stall_b = 1'b0;
    for (int i = 0; i < 2**AW; i++) begin
      ram_a[i] = DW'(i + 1);
      ram_b[i] = DW'(i + 1);
    end

    // Single-frame run, stall in mid-stream, and ignored extra starts.
    add(1,1,0,0,0,0,0,0,0,0,0);
    add(1,0,0,1,0,0,0,0,0,1,0);
    add(1,0,0,1,1,0,0,0,0,1,0);
    add(1,0,0,1,2,1,1,1,0,1,0);
    add(1,0,0,1,3,1,2,0,0,1,0);
    add(1,0,0,1,4,1,3,0,0,1,0);
    add(1,0,0,1,5,1,4,0,0,1,0);
    add(1,0,0,1,6,1,5,0,0,1,0);
    add(1,0,0,1,7,1,6,0,0,1,0);
    add(1,0,0,1,8,1,7,0,0,1,0);
    add(1,0,0,0,0,1,8,0,0,1,0);
    add(1,0,0,0,0,1,9,0,1,1,0);
    add(1,0,0,0,0,0,0,0,0,1,1);
    add(1,0,0,0,0,0,0,0,0,0,0);

    add(3,1,0,0,0,0,0,0,0,0,0);
    add(3,0,0,1,0,0,0,0,0,1,0);
    add(3,0,0,1,1,0,0,0,0,1,0);
    add(3,0,0,1,2,1,1,1,0,1,0);
    add(3,0,0,1,3,1,2,0,0,1,0);
    add(3,0,1,0,0,1,3,0,0,1,0);
    add(3,0,1,0,0,1,4,0,0,1,0);
    add(3,0,1,0,0,0,0,0,0,1,0);
    add(3,0,0,1,4,0,0,0,0,1,0);
    add(3,0,0,1,5,0,0,0,0,1,0);
    add(3,0,0,1,6,1,5,0,0,1,0);
    add(3,0,0,1,7,1,6,0,0,1,0);
    add(3,0,0,1,8,1,7,0,0,1,0);
    add(3,0,0,0,0,1,8,0,0,1,0);
    add(3,0,0,0,0,1,9,0,1,1,0);
    add(3,0,0,0,0,0,0,0,0,1,1);
    add(3,0,0,0,0,0,0,0,0,0,0);

    add(5,1,0,0,0,0,0,0,0,0,0);
    add(5,0,0,1,0,0,0,0,0,1,0);
    add(5,0,0,1,1,0,0,0,0,1,0);
    add(5,0,0,1,2,1,1,1,0,1,0);
    add(5,0,0,1,3,1,2,0,0,1,0);
    add(5,1,0,1,4,1,3,0,0,1,0);
    add(5,0,0,1,5,1,4,0,0,1,0);
    add(5,0,0,1,6,1,5,0,0,1,0);
    add(5,0,0,1,7,1,6,0,0,1,0);
    add(5,0,0,1,8,1,7,0,0,1,0);
    add(5,0,1,0,0,1,8,0,0,1,0);
    add(5,0,1,0,0,1,9,0,1,1,0);
    add(5,1,0,0,0,0,0,0,0,1,1);
    add(5,0,1,0,0,0,0,0,0,0,0);
    add(5,0,0,0,0,0,0,0,0,0,0);

    #3;
    check_all_zero_a("reset_a");
    chk("reset_b valid_out", v_b, 0);
    chk("reset_b busy", busy_b, 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;

`ifndef FMAP_ZERO_PAD_EN
    foreach (tbl[i]) begin
      start_a = tbl[i].st;
      stall_a = tbl[i].sl;
      @(negedge clk);
      chk($sformatf("t%0d row%0d valid_out", tbl[i].tst, i), v_a, tbl[i].v);
      chk($sformatf("t%0d row%0d mem_rd_en", tbl[i].tst, i), rd_a, tbl[i].rd);
      chk($sformatf("t%0d row%0d sof_out", tbl[i].tst, i), sof_a, tbl[i].so);
      chk($sformatf("t%0d row%0d eof_out", tbl[i].tst, i), eof_a, tbl[i].eo);
      chk($sformatf("t%0d row%0d busy", tbl[i].tst, i), busy_a, tbl[i].b);
      chk($sformatf("t%0d row%0d done", tbl[i].tst, i), done_a, tbl[i].d);
      if (tbl[i].v) chk($sformatf("t%0d row%0d pxl_out", tbl[i].tst, i), pxl_a, tbl[i].p);
      if (tbl[i].rd) chk($sformatf("t%0d row%0d mem_addr", tbl[i].tst, i), addr_a, tbl[i].ad);
      @(posedge clk); #1;
    end
    start_a = 1'b0; stall_a = 1'b0;

    // Two frames back to back with no gap between them.
    for (int c = 0; c < 24; c++) begin
      start_b = (c == 0);
      @(negedge clk);
      chk($sformatf("t2 c%0d valid_out", c), v_b, (c >= 3 && c <= 20));
      if (c >= 3 && c <= 20) chk($sformatf("t2 c%0d pxl_out", c), pxl_b, ((c - 3) % 9) + 1);
      chk($sformatf("t2 c%0d sof_out", c), sof_b, (c == 3 || c == 12));
      chk($sformatf("t2 c%0d eof_out", c), eof_b, (c == 11 || c == 20));
      chk($sformatf("t2 c%0d done", c), done_b, (c == 21));
      chk($sformatf("t2 c%0d busy", c), busy_b, (c >= 1 && c <= 21));
      @(posedge clk); #1;
    end
    start_b = 1'b0;
`endif

    // Asynchronous reset in mid-stream, then a clean restart.
    start_a = 1'b1;
    for (int c = 0; c < 6; c++) begin
      @(posedge clk); #1;
      start_a = 1'b0;
    end
    chk("t4 busy_before_reset", busy_a, 1);
    rst_n = 1'b0;
    #2;
    check_all_zero_a("t4 async_reset");
    @(posedge clk); #1;
    check_all_zero_a("t4 held_reset");
    rst_n = 1'b1;
    @(posedge clk); #1;
    run_a(40);
    check_run_a("t4 restart");

    run_a(40);
    check_run_a("t6 run");
`ifdef FMAP_ZERO_PAD_EN
    chk("t6 pad corner", got_a[0], 0);
    chk("t6 first interior", got_a[6], 1);
    chk("t6 last interior", got_a[18], 9);
    chk("t6 right border", got_a[9], 0);
    chk("t6 bottom row", got_a[22], 0);
`endif

    // Random map contents, random stalls, stray starts while busy.
    for (int run = 0; run < 6; run++) begin
      for (int i = 0; i < D * D; i++) ram_b[i] = $urandom;
      exp_q.delete();
      for (int k = 0; k < FB * SS; k++) exp_q.push_back(ref_pix(k, 1'b1));
      idx = 0; nd = 0; last_v = -1; done_c = -1;
      start_b = 1'b1;
      stall_b = 1'b0;
      for (int c = 0; c < 400; c++) begin
        @(negedge clk);
        if (v_b) begin
          if (idx < exp_q.size()) begin
            chk($sformatf("rand r%0d px%0d pxl_out", run, idx), pxl_b, exp_q[idx]);
            chk($sformatf("rand r%0d px%0d sof_out", run, idx), sof_b, (idx % SS == 0));
            chk($sformatf("rand r%0d px%0d eof_out", run, idx), eof_b, (idx % SS == SS - 1));
          end
          idx++;
          last_v = c;
        end
        if (done_b) begin nd++; done_c = c; end
        @(posedge clk); #1;
        start_b = (nd == 0 && c >= 2 && $urandom_range(0, 7) == 0);
        stall_b = ($urandom_range(0, 3) == 0);
        if (nd != 0) break;
      end
      start_b = 1'b0;
      stall_b = 1'b0;
      chk($sformatf("rand r%0d done_seen", run), nd, 1);
      chk($sformatf("rand r%0d valid_count", run), idx, FB * SS);
      chk($sformatf("rand r%0d done_after_last_valid", run), done_c, last_v + 1);
      for (int c = 0; c < 3; c++) begin
        @(negedge clk);
        chk($sformatf("rand r%0d idle%0d busy", run, c), busy_b, 0);
        chk($sformatf("rand r%0d idle%0d valid_out", run, c), v_b, 0);
        @(posedge clk); #1;
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
